// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller and ALU: FSM states,
// opcode/funct fields, ALU operation codes and datapath select values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decode; flags funct codes the ALU does not
// implement so the controller can suppress the register write-back.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       known
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring a latch.
    alu_op = ALU_NOP;
    known  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_SLT:  alu_op = ALU_SLT;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      default: known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset controller: Moore FSM driving datapath selects and
// strobes, plus a wrapping count of retired instructions.
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [31:0] retired,
  output logic [3:0]  state_o
);

  state_t      state, next_state;
  logic [5:0]  funct_q;
  logic [31:0] retired_q;
  logic [3:0]  fn_alu_op;
  logic        fn_known;
  logic        pc_write, branch_state;
  logic        retire;

  alu_decoder u_alu_decoder (
    .funct  (funct_q),
    .alu_op (fn_alu_op),
    .known  (fn_known)
  );

  // Any move into FETCH from another state completes (or discards) an instruction.
  assign retire  = (next_state == S_FETCH) && (state != S_FETCH);
  assign retired = retired_q;
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= S_FETCH;
      funct_q   <= '0;
      retired_q <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) funct_q <= funct;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op       = ALU_NOP;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    pc_src       = PCSRC_ALU;
    pc_write     = 1'b0;
    branch_state = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = fn_alu_op;
      end
      S_ALUWB: begin
        reg_write = fn_known;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = ALU_SUB;
        pc_src       = PCSRC_BR;
        branch_state = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JMP;
        pc_write = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    pc_en = pc_write | (branch_state & zero);
    // Reset parks the FSM in FETCH; keep its strobes quiet until release.
    if (!rst_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: opcode  input  6  instruction bits [31:26], valid from DECODE onward.
REQ-004 SHALL: funct  input  6  instruction bits [5:0], valid from DECODE onward.
REQ-005 SHALL: zero  input  1  ALU zero flag, sampled in BRANCH only.
REQ-006 SHALL: alu_op  output  4  ALU operation: 0010 add, 0110 sub, 0111 slt, 0000 and, 0001 or, 1111 nop.
REQ-007 SHALL: alu_src_a  output  1  0 = PC, 1 = register A.
REQ-008 SHALL: alu_src_b  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-009 SHALL: pc_en, pc_src[1:0], ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg  outputs  datapath strobes/selects.
REQ-010 SHALL: retired  output  32  count of completed instructions.
REQ-011 SHALL: state_o  output  4  current state encoding, debug only.

Function
REQ-012 SHALL: implement a Moore FSM; all outputs except pc_en are decoded from the state register only.
REQ-013 SHALL: pc_en = pc_write_state | (branch_state & zero), combinational.
REQ-014 SHALL: states and transitions:
- FETCH -> DECODE
- DECODE -> MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j), FETCH (other)
- MEMADR -> MEMRD (lw) / MEMWR (sw)
- MEMRD -> MEMWB
- EXEC -> ALUWB
- ADDIEX -> ADDIWB
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH
REQ-015 SHALL: use opcodes R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-016 SHALL: FETCH outputs: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=0010, pc_src=00, pc_write=1.
REQ-017 SHALL: DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=0010 (branch target precompute).
REQ-018 SHALL: MEMADR and ADDIEX outputs: alu_src_a=1, alu_src_b=10, alu_op=0010.
REQ-019 SHALL: MEMRD outputs mem_read=1, iord=1; MEMWR outputs mem_write=1, iord=1; MEMWB outputs reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-020 SHALL: EXEC drives alu_src_a=1, alu_src_b=00, and alu_op from funct: 100000->0010, 100010->0110, 101010->0111, 100100->0000, 100101->0001, any other->1111.
REQ-021 SHALL: in ALUWB, assert reg_write=1, reg_dst=1, mem_to_reg=0, except for an unrecognised funct, where reg_write=0.
REQ-022 SHALL: BRANCH outputs alu_src_a=1, alu_src_b=00, alu_op=0110, pc_src=01, branch_state=1.
REQ-023 SHALL: JUMP outputs pc_src=10, pc_write=1.
REQ-024 SHALL: ADDIWB outputs reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-025 SHALL: outputs not listed for a state default to 0; alu_op defaults to 1111.
REQ-026 SHALL: increment retired (mod 2^32, wrapping) on every transition into FETCH from a terminal state.
REQ-027 SHALL: retire an unknown opcode in DECODE->FETCH, with no reg_write or mem_write and a single FETCH pc update.
REQ-028 SHALL: have latencies lw 5, sw 4, R 4, addi 4, beq 3, j 3, unknown 2 cycles.
REQ-029 SHALL: hold funct captured at DECODE; changes on the funct input during EXEC/ALUWB affect only combinational alu_op decode, and the integrator keeps the IR stable.

Reset
REQ-030 SHALL: on rst_n=0, immediately force state=FETCH, retired=0, and all strobes to their non-FETCH-safe values; pc_en=0, mem_write=0, reg_write=0 while reset is asserted.
REQ-031 SHALL: on reset mid-instruction, abandon the instruction without a retired increment; first active edge after release executes FETCH.

Structure
REQ-032 SHALL: place state encodings, opcode constants, funct constants and alu_op codes in a shared package mc_pkg, also used by the ALU.
REQ-033 SHALL: put funct-to-alu_op decode in one combinational sub-module alu_decoder; the FSM instantiates it.

Verification
REQ-034 SHALL: bench covers R add (opcode 000000, funct 100000): alu_op=0010 in EXEC, reg_write=1 in ALUWB, 4 cycles, retired 0->1.
REQ-035 SHALL: bench covers beq with zero=1: pc_en=1, pc_src=01 in BRANCH; with zero=0: pc_en=0; 3 cycles each.
REQ-036 SHALL: bench covers lw (100011): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; mem_to_reg=1 in MEMWB.
REQ-037 SHALL: bench covers funct 000111 (unknown): alu_op=1111 and reg_write=0 throughout the instruction; opcode 111111 returns to FETCH after DECODE.
REQ-038 SHALL: bench covers rst_n pulse low mid-MEMRD: state=FETCH asynchronously, retired=0, mem_write=0.
REQ-039 SHALL: bench covers retired preloaded via force to 0xFFFFFFFF, then one j: retired=0x00000000.
